// File: rtl/lcd_i2c_ctrl_if.sv
// Command (valid/ready) and byte-level I2C master signals of the HD44780/PCF8574 controller.
// The controller is the slave side; the environment (application plus I2C master) is the master side.
interface lcd_i2c_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_we;
  logic       i2c_busy;

  modport master (output cmd_valid, cmd_rs, cmd_data, i2c_busy,
                  input  cmd_ready, i2c_addr, i2c_data, i2c_we);
  modport slave  (input  cmd_valid, cmd_rs, cmd_data, i2c_busy,
                  output cmd_ready, i2c_addr, i2c_data, i2c_we);
endinterface

// File: rtl/lcd_i2c_ctrl.sv
// HD44780 4-bit controller behind a PCF8574 backpack: power-on init, then command/data bytes as E-strobed nibbles.
// Optional cursor tracking with automatic line wrap when the macro AUTO_WRAP_EN is defined.
module lcd_i2c_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter logic [6:0]  I2C_ADDR  = 7'h27,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COLS      = 16,
  parameter logic        BACKLIGHT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  lcd_i2c_ctrl_if.slave bus,
  input  logic          bl_set,
  input  logic          bl_val,
  output logic          init_done,
  output logic          busy
);
  localparam int unsigned US = CLK_HZ / 1_000_000;

  if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 40) begin : g_bad_geometry
    $error("lcd_i2c_ctrl: ROWS must be 1..4 and COLS 1..40");
  end

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, IDLE, NIB_E1, NIB_E0, DELAY
`ifdef AUTO_WRAP_EN
    , WRAP
`endif
  } state_t;
  typedef enum logic [1:0] {PH_WAIT, PH_REQ, PH_XFER} phase_t;

  function automatic logic [31:0] dly(input logic [15:0] us);
    return (us == 16'd0) ? 32'd0 : 32'(us) * 32'(US) - 32'd1;
  endfunction

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  init_idx, init_idx_d;
  logic        lat_rs, lat_rs_d;
  logic [7:0]  lat_data, lat_data_d;
  logic        hi_sel, hi_sel_d, single, single_d, next_e0, next_e0_d;
  logic        bl, bl_d, done_q, done_d, we_q, we_d, ready_q, ready_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  nib;
  logic [15:0] post_us;
  logic [7:0]  init_byte;
  logic        end_unit, byte_done;

`ifdef AUTO_WRAP_EN
  localparam logic [6:0] ROW_OFF [4] = '{7'h00, 7'h40, 7'h14, 7'h54};
  logic [1:0] row, row_d, row_nx;
  logic [5:0] col, col_d;
  logic       matched;
  assign row_nx = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;
`endif

  assign bus.i2c_addr  = I2C_ADDR;
  assign bus.i2c_data  = data_q;
  assign bus.i2c_we    = we_q;
  assign bus.cmd_ready = ready_q;
  assign init_done     = done_q;
  assign busy          = (state != IDLE);

  // Single init nibbles occupy the high half of lat_data and end their unit after one nibble.
  always_comb begin
    case (init_idx)
      4'd4:    init_byte = 8'h28;
      4'd5:    init_byte = 8'h08;
      4'd6:    init_byte = 8'h01;
      4'd7:    init_byte = 8'h06;
      default: init_byte = 8'h0C;
    endcase
    nib      = hi_sel ? lat_data[7:4] : lat_data[3:0];
    end_unit = single || !hi_sel;
    if (single)
      post_us = (init_idx == 4'd0) ? 16'd4100 : 16'd100;
    else if (!lat_rs && (lat_data == 8'h01 || lat_data == 8'h02))
      post_us = 16'd2000;
    else
      post_us = 16'd53;
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    cnt_d      = cnt;
    init_idx_d = init_idx;
    lat_rs_d   = lat_rs;
    lat_data_d = lat_data;
    hi_sel_d   = hi_sel;
    single_d   = single;
    next_e0_d  = next_e0;
    done_d     = done_q;
    data_d     = data_q;
    we_d       = we_q;
    bl_d       = bl_set ? bl_val : bl;
    byte_done  = 1'b0;
`ifdef AUTO_WRAP_EN
    row_d   = row;
    col_d   = col;
    matched = 1'b0;
`endif

    // Per-byte handshake: wait for an idle master, hold we until busy is seen, then wait for busy to fall.
    if (state == NIB_E1 || state == NIB_E0) begin
      case (phase)
        PH_WAIT: if (!bus.i2c_busy) begin
          we_d    = 1'b1;
          data_d  = {nib, bl_d, (state == NIB_E1), 1'b0, lat_rs};
          phase_d = PH_REQ;
        end
        PH_REQ: if (bus.i2c_busy) begin
          we_d    = 1'b0;
          phase_d = PH_XFER;
        end
        default: if (!bus.i2c_busy) begin
          phase_d   = PH_WAIT;
          byte_done = 1'b1;
        end
      endcase
    end

    case (state)
      PWR_WAIT: if (cnt == 32'd0) state_d = INIT_NIB; else cnt_d = cnt - 32'd1;
      INIT_NIB: begin
        lat_rs_d = 1'b0;
        hi_sel_d = 1'b1;
        single_d = (init_idx < 4'd4);
        lat_data_d = (init_idx < 4'd4) ? {((init_idx == 4'd3) ? 4'h2 : 4'h3), 4'h0} : init_byte;
        state_d = NIB_E1;
      end
      IDLE: if (bus.cmd_valid && ready_q) begin
        lat_rs_d   = bus.cmd_rs;
        lat_data_d = bus.cmd_data;
        hi_sel_d   = 1'b1;
        single_d   = 1'b0;
        state_d    = NIB_E1;
      end
      NIB_E1: if (byte_done) begin
        cnt_d = dly(16'd1); next_e0_d = 1'b1; state_d = DELAY;
      end
      NIB_E0: if (byte_done) begin
        cnt_d = dly(end_unit ? post_us : 16'd1); next_e0_d = 1'b0; state_d = DELAY;
      end
      DELAY: if (!bus.i2c_busy) begin
        if (cnt != 32'd0) cnt_d = cnt - 32'd1;
        else if (next_e0) state_d = NIB_E0;
        else if (!end_unit) begin
          hi_sel_d = 1'b0;
          state_d  = NIB_E1;
        end else if (!done_q) begin
          if (init_idx == 4'd8) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            init_idx_d = init_idx + 4'd1;
            state_d    = INIT_NIB;
          end
        end else begin
          state_d = IDLE;
`ifdef AUTO_WRAP_EN
          // Unmatched DDRAM addresses fall back to row 0 with the column folded into range.
          if (lat_rs) begin
            col_d = col + 6'd1;
            if (col == 6'(COLS - 1)) state_d = WRAP;
          end else if (lat_data == 8'h01 || lat_data == 8'h02) begin
            row_d = 2'd0;
            col_d = 6'd0;
          end else if (lat_data[7]) begin
            row_d = 2'd0;
            col_d = 6'(lat_data[6:0] % 7'(COLS));
            for (int r = 0; r < int'(ROWS); r++) begin
              if (!matched && lat_data[6:0] >= ROW_OFF[2'(r)] &&
                  8'(lat_data[6:0]) < 8'(ROW_OFF[2'(r)]) + 8'(COLS)) begin
                matched = 1'b1;
                row_d   = 2'(r);
                col_d   = 6'(lat_data[6:0] - ROW_OFF[2'(r)]);
              end
            end
          end
`endif
        end
      end
`ifdef AUTO_WRAP_EN
      WRAP: begin
        row_d      = row_nx;
        col_d      = 6'd0;
        lat_rs_d   = 1'b0;
        lat_data_d = {1'b1, ROW_OFF[row_nx]};
        hi_sel_d   = 1'b1;
        single_d   = 1'b0;
        state_d    = NIB_E1;
      end
`endif
      default: state_d = PWR_WAIT;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWR_WAIT;
      phase    <= PH_WAIT;
      cnt      <= dly(16'd40000);
      init_idx <= 4'd0;
      lat_rs   <= 1'b0;
      lat_data <= 8'h00;
      hi_sel   <= 1'b0;
      single   <= 1'b0;
      next_e0  <= 1'b0;
      bl       <= BACKLIGHT;
      done_q   <= 1'b0;
      data_q   <= 8'h00;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
`ifdef AUTO_WRAP_EN
      row      <= 2'd0;
      col      <= 6'd0;
`endif
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      cnt      <= cnt_d;
      init_idx <= init_idx_d;
      lat_rs   <= lat_rs_d;
      lat_data <= lat_data_d;
      hi_sel   <= hi_sel_d;
      single   <= single_d;
      next_e0  <= next_e0_d;
      bl       <= bl_d;
      done_q   <= done_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
`ifdef AUTO_WRAP_EN
      row      <= row_d;
      col      <= col_d;
`endif
    end
  end
endmodule
